acc_src_select: RTL and testbench

Parametrised, registered source selector that feeds the 8-bit datapath's accumulator/ALU operand. It generalises the two-input combinational operand mux to NSRC channels of WIDTH bits. Each channel offers data with a valid/ready handshake, and one output register presents the result downstream with a valid/ready handshake. Channel choice is either fixed by `sel` or round-robin across valid channels. A wrapping counter records completed output transfers.

---
 rtl/acc_src_select.sv | 119 +++++++++++
 tb/tb_acc_src_select.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/acc_src_select.sv
// Registered NSRC-to-1 operand source selector with fixed or round-robin channel choice.
// One output register with valid/ready handshake and a wrapping transfer counter.
module acc_src_select #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned SELW  = (NSRC > 1) ? $clog2(NSRC) : 1,
  parameter int unsigned CNTW  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NSRC*WIDTH-1:0]   in_data,
  input  logic [NSRC-1:0]         in_valid,
  output logic [NSRC-1:0]         in_ready,
  input  logic                    mode,
  input  logic [SELW-1:0]         sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SELW-1:0]         out_src,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNTW-1:0]         xfer_count
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              drain_c;
  logic              can_load_c;
  logic              load_c;
  logic              gnt_vld_c;
  logic [SELW-1:0]   gnt_c;
  logic [SELW-1:0]   ptr_q;
  logic [SELW-1:0]   ptr_nxt_c;
  logic [WIDTH-1:0]  gnt_data_c;

  assign out_valid  = (state_q == S_FULL);
  assign drain_c    = out_valid & out_ready;
  assign can_load_c = (state_q == S_EMPTY) | drain_c;
  // Loading is suppressed while reset is low so no channel sees a spurious accept.
  assign load_c     = rst_n & can_load_c & gnt_vld_c;

  // Grant: fixed index, or first valid channel scanning upward from ptr with wrap.
  always_comb begin
    int unsigned idx;
    gnt_vld_c = 1'b0;
    gnt_c     = '0;
    idx       = 0;
    if (!mode) begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (32'(sel) == i && in_valid[i]) begin
          gnt_vld_c = 1'b1;
          gnt_c     = SELW'(i);
        end
      end
    end else begin
      for (int unsigned k = 0; k < NSRC; k++) begin
        idx = 32'(ptr_q) + k;
        if (idx >= NSRC) idx = idx - NSRC;
        for (int unsigned i = 0; i < NSRC; i++) begin
          if (!gnt_vld_c && idx == i && in_valid[i]) begin
            gnt_vld_c = 1'b1;
            gnt_c     = SELW'(i);
          end
        end
      end
    end
  end

  // Granted channel data and one-hot accept.
  always_comb begin
    gnt_data_c = '0;
    in_ready   = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (32'(gnt_c) == i) gnt_data_c = in_data[i*WIDTH +: WIDTH];
      in_ready[i] = load_c && (32'(gnt_c) == i);
    end
  end

  always_comb begin
    logic [31:0] nxt;
    nxt       = 32'(gnt_c) + 32'd1;
    ptr_nxt_c = (nxt >= NSRC) ? '0 : SELW'(nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (load_c) state_d = S_FULL;
      S_FULL:  if (drain_c && !load_c) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // Output register, transfer counter and rotation pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_src    <= '0;
      xfer_count <= '0;
      ptr_q      <= '0;
    end else begin
      if (load_c) begin
        out_data <= gnt_data_c;
        out_src  <= gnt_c;
      end
      if (drain_c) xfer_count <= xfer_count + CNTW'(1);
      if (load_c && mode) ptr_q <= ptr_nxt_c;
    end
  end

endmodule

// File: tb/tb_acc_src_select.sv
// Directed bench for acc_src_select using NSRC=2, NSRC=4 and NSRC=3 instances.
module tb_acc_src_select;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // NSRC=2 instance
  logic [15:0] a_in_data;
  logic [1:0]  a_in_valid, a_in_ready;
  logic        a_mode;
  logic [0:0]  a_sel;
  logic [7:0]  a_out_data;
  logic [0:0]  a_out_src;
  logic        a_out_valid, a_out_ready;
  logic [7:0]  a_cnt;

  // NSRC=4 instance
  logic [31:0] b_in_data;
  logic [3:0]  b_in_valid, b_in_ready;
  logic        b_mode;
  logic [1:0]  b_sel;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_src;
  logic        b_out_valid, b_out_ready;
  logic [7:0]  b_cnt;

  // NSRC=3 instance
  logic [23:0] c_in_data;
  logic [2:0]  c_in_valid, c_in_ready;
  logic        c_mode;
  logic [1:0]  c_sel;
  logic [7:0]  c_out_data;
  logic [1:0]  c_out_src;
  logic        c_out_valid, c_out_ready;
  logic [7:0]  c_cnt;

  acc_src_select #(.WIDTH(8), .NSRC(2), .CNTW(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .mode(a_mode), .sel(a_sel), .out_data(a_out_data),
    .out_src(a_out_src), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .xfer_count(a_cnt));

  acc_src_select #(.WIDTH(8), .NSRC(4), .CNTW(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .mode(b_mode), .sel(b_sel), .out_data(b_out_data),
    .out_src(b_out_src), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .xfer_count(b_cnt));

  acc_src_select #(.WIDTH(8), .NSRC(3), .CNTW(8)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .mode(c_mode), .sel(c_sel), .out_data(c_out_data),
    .out_src(c_out_src), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .xfer_count(c_cnt));

  task automatic idle_inputs();
    a_in_data = '0; a_in_valid = '0; a_mode = 1'b0; a_sel = '0; a_out_ready = 1'b0;
    b_in_data = '0; b_in_valid = '0; b_mode = 1'b0; b_sel = '0; b_out_ready = 1'b0;
    c_in_data = '0; c_in_valid = '0; c_mode = 1'b0; c_sel = '0; c_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    a_in_data = {8'd9, 8'd4}; a_in_valid = 2'b11; a_out_ready = 1'b1;
    b_in_valid = 4'b1111; b_mode = 1'b1; b_out_ready = 1'b1;
    c_in_valid = 3'b111; c_out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 2'b00) begin errors++; $display("FAIL rst_a_in_ready got %b want 00", a_in_ready); end
    checks++; if (b_in_ready !== 4'b0000) begin errors++; $display("FAIL rst_b_in_ready got %b want 0000", b_in_ready); end
    checks++; if (c_in_ready !== 3'b000) begin errors++; $display("FAIL rst_c_in_ready got %b want 000", c_in_ready); end
    @(posedge clk); #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_a_out_valid got %b want 0", a_out_valid); end
    checks++; if (a_out_data !== 8'd0) begin errors++; $display("FAIL rst_a_out_data got %0d want 0", a_out_data); end
    checks++; if (a_cnt !== 8'd0) begin errors++; $display("FAIL rst_a_cnt got %0d want 0", a_cnt); end
    checks++; if (b_out_valid !== 1'b0 || b_out_src !== 2'd0) begin errors++; $display("FAIL rst_b_out got v=%b src=%0d want v=0 src=0", b_out_valid, b_out_src); end
    checks++; if (c_out_valid !== 1'b0 || c_cnt !== 8'd0) begin errors++; $display("FAIL rst_c_out got v=%b cnt=%0d want 0 0", c_out_valid, c_cnt); end
    rst_n = 1'b1;
    #1;
    checks++; if (a_in_ready !== 2'b01) begin errors++; $display("FAIL post_rst_a_in_ready got %b want 01", a_in_ready); end
    idle_inputs();
  endtask

  task automatic test_fixed_sel();
    do_reset();
    a_in_data = {8'd28, 8'd2}; a_in_valid = 2'b11; a_sel = 1'b1; a_out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 2'b10) begin errors++; $display("FAIL fixed_in_ready got %b want 10", a_in_ready); end
    @(posedge clk); #1;
    checks++; if (a_out_data !== 8'd28 || a_out_src !== 1'b1 || a_out_valid !== 1'b1)
      begin errors++; $display("FAIL fixed_load got d=%0d src=%0d v=%b want 28 1 1", a_out_data, a_out_src, a_out_valid); end
    a_in_valid = 2'b00;
    @(posedge clk); #1;
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 8'd28 || a_cnt !== 8'd1)
      begin errors++; $display("FAIL fixed_drain got v=%b d=%0d cnt=%0d want 0 28 1", a_out_valid, a_out_data, a_cnt); end
  endtask

  task automatic test_fixed_stall();
    do_reset();
    a_in_data = {8'd7, 8'd30}; a_in_valid = 2'b11; a_sel = 1'b0; a_out_ready = 1'b0;
    #1;
    checks++; if (a_in_ready !== 2'b01) begin errors++; $display("FAIL stall_first_ready got %b want 01", a_in_ready); end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (a_in_ready !== 2'b00 || a_out_data !== 8'd30 || a_out_valid !== 1'b1)
        begin errors++; $display("FAIL stall_hold[%0d] got rdy=%b d=%0d v=%b want 00 30 1", k, a_in_ready, a_out_data, a_out_valid); end
      @(posedge clk); #1;
    end
    checks++; if (a_cnt !== 8'd0) begin errors++; $display("FAIL stall_no_count got %0d want 0", a_cnt); end
    a_in_valid = 2'b00; a_out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_cnt !== 8'd1 || a_out_valid !== 1'b0)
      begin errors++; $display("FAIL stall_release got cnt=%0d v=%b want 1 0", a_cnt, a_out_valid); end
    a_out_ready = 1'b0;
  endtask

  task automatic test_rr_fair();
    logic [3:0] exp_rdy;
    do_reset();
    b_mode = 1'b1; b_in_valid = 4'b1111; b_out_ready = 1'b1;
    b_in_data = {8'd13, 8'd12, 8'd11, 8'd10};
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_rdy = 4'(1 << (k % 4));
      checks++; if (b_in_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", k, b_in_ready, exp_rdy); end
      @(posedge clk); #1;
      checks++; if (b_out_data !== 8'(10 + k % 4) || b_out_src !== 2'(k % 4) || b_out_valid !== 1'b1)
        begin errors++; $display("FAIL rr_data[%0d] got d=%0d src=%0d v=%b want %0d %0d 1", k, b_out_data, b_out_src, b_out_valid, 10 + k % 4, k % 4); end
    end
    checks++; if (b_cnt !== 8'd5) begin errors++; $display("FAIL rr_count got %0d want 5", b_cnt); end
  endtask

  task automatic test_rr_skip();
    logic       m_tab [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] v_tab [6] = '{4'b0100, 4'b0101, 4'b0101, 4'b0111, 4'b0101, 4'b0101};
    logic [1:0] s_tab [6] = '{2'd2, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2};
    do_reset();
    b_in_data = {8'd13, 8'd12, 8'd11, 8'd10}; b_out_ready = 1'b1; b_sel = 2'd1;
    for (int k = 0; k < 6; k++) begin
      b_mode = m_tab[k]; b_in_valid = v_tab[k];
      #1;
      checks++; if (b_in_ready !== 4'(1 << s_tab[k])) begin errors++; $display("FAIL skip_ready[%0d] got %b want %b", k, b_in_ready, 4'(1 << s_tab[k])); end
      @(posedge clk); #1;
      checks++; if (b_out_src !== s_tab[k] || b_out_data !== 8'(10 + s_tab[k]))
        begin errors++; $display("FAIL skip_src[%0d] got src=%0d d=%0d want %0d %0d", k, b_out_src, b_out_data, s_tab[k], 10 + s_tab[k]); end
    end
    checks++; if (b_cnt !== 8'd5) begin errors++; $display("FAIL skip_count got %0d want 5", b_cnt); end
  endtask

  task automatic test_oob_sel();
    do_reset();
    c_in_data = {8'd3, 8'd2, 8'd1}; c_in_valid = 3'b111; c_sel = 2'd3; c_out_ready = 1'b1;
    #1;
    checks++; if (c_in_ready !== 3'b000) begin errors++; $display("FAIL oob_ready got %b want 000", c_in_ready); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL oob_valid got %b want 0", c_out_valid); end
    c_sel = 2'd2;
    #1;
    checks++; if (c_in_ready !== 3'b100) begin errors++; $display("FAIL inrange_ready got %b want 100", c_in_ready); end
    @(posedge clk); #1;
    checks++; if (c_out_data !== 8'd3 || c_out_src !== 2'd2 || c_out_valid !== 1'b1)
      begin errors++; $display("FAIL inrange_load got d=%0d src=%0d v=%b want 3 2 1", c_out_data, c_out_src, c_out_valid); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    a_in_data = {8'hA5, 8'h5A}; a_in_valid = 2'b10; a_sel = 1'b1; a_out_ready = 1'b1;
    repeat (256) @(posedge clk);
    #1;
    checks++; if (a_cnt !== 8'd255 || a_out_valid !== 1'b1)
      begin errors++; $display("FAIL wrap_pre got cnt=%0d v=%b want 255 1", a_cnt, a_out_valid); end
    @(posedge clk); #1;
    checks++; if (a_cnt !== 8'd0 || a_out_valid !== 1'b1)
      begin errors++; $display("FAIL wrap_roll got cnt=%0d v=%b want 0 1", a_cnt, a_out_valid); end
    repeat (255) @(posedge clk);
    #1;
    checks++; if (a_cnt !== 8'd255 || a_out_data !== 8'hA5 || a_out_src !== 1'b1)
      begin errors++; $display("FAIL wrap_full got cnt=%0d d=%0h src=%0d want 255 a5 1", a_cnt, a_out_data, a_out_src); end
    a_out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 8'd0 || a_out_src !== 1'b0 || a_cnt !== 8'd0)
      begin errors++; $display("FAIL wrap_reset got v=%b d=%0d src=%0d cnt=%0d want all 0", a_out_valid, a_out_data, a_out_src, a_cnt); end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #2;
    test_reset();
    test_fixed_sel();
    test_fixed_stall();
    test_rr_fair();
    test_rr_skip();
    test_oob_sel();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
